// File: rtl/uart_mirror_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_mirror_fifo
// Description : UART byte mirror with a receive FIFO and optional upper-casing
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mirror_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_ready,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     tx_busy,
    input  logic                     upcase,
    input  logic                     clr_overflow,
    output logic                     tx_start,
    output logic [WIDTH-1:0]         tx_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [WIDTH-1:0]         last_byte
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] last_byte_q, last_byte_d;
    logic             tx_start_q, tx_start_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;

    logic             w_pop, w_push, w_drop;
    logic [WIDTH-1:0] w_rd_raw, w_rd_out;

    assign w_pop    = (state_q == ST_IDLE) && (count_q != '0) && !tx_busy;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push   = rx_ready && ((count_q < C_DEPTH) || w_pop);
    assign w_drop   = rx_ready && !w_push;
    assign w_rd_raw = mem_q[rp_q];

    if (WIDTH == 8) begin : g_upcase
        always_comb begin
            w_rd_out = w_rd_raw;
            if (upcase && (w_rd_raw >= 8'h61) && (w_rd_raw <= 8'h7A)) begin
                w_rd_out = w_rd_raw - 8'h20;
            end
        end
    end else begin : g_no_upcase
        assign w_rd_out = w_rd_raw;
    end

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        last_byte_d = last_byte_q;
        tx_start_d  = w_pop;
        tx_data_d   = tx_data_q;

        case (state_q)
            ST_IDLE:  if (w_pop) state_d = ST_START;
            ST_START: state_d = ST_GUARD;
            ST_GUARD: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (w_pop) begin
            tx_data_d = w_rd_out;
            rp_d      = rp_q + AW'(1);
        end
        if (w_push) begin
            wp_d = wp_q + AW'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (rx_ready) begin
            last_byte_d = rx_data;
        end

        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wp_q] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            last_byte_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            last_byte_q <= last_byte_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign last_byte = last_byte_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_mirror_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mirror_fifo
// Description : Self-checking bench for uart_mirror_fifo (DEPTH = 4)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mirror_fifo;
    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       upcase;
    logic       clr_overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [2:0] count;
    logic       overflow;
    logic [7:0] last_byte;

    uart_mirror_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .tx_busy      (tx_busy),
        .upcase       (upcase),
        .clr_overflow (clr_overflow),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .count        (count),
        .overflow     (overflow),
        .last_byte    (last_byte)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       rx;
        logic [7:0] d;
        logic       busy;
        logic       up;
        logic       clr;
        logic       st;
        logic [7:0] td;
        logic [2:0] cnt;
        logic       ovf;
        logic [7:0] last;
    } vec_t;

    vec_t tbl [18];

    // Reference model: a byte queue plus the number of edges since the last start pulse.
    logic [7:0] mq [$];
    int         m_since;
    logic       m_start;
    logic [7:0] m_data;
    logic       m_ovf;
    logic [7:0] m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_since = 3;
        m_start = 1'b0;
        m_data  = 8'h00;
        m_ovf   = 1'b0;
        m_last  = 8'h00;
    endtask

    task automatic model_edge();
        logic [7:0] b;
        logic       drop;
        drop    = 1'b0;
        m_since = (m_since < 100) ? m_since + 1 : m_since;
        m_start = 1'b0;
        if (mq.size() > 0 && !tx_busy && m_since >= 3) begin
            b = mq.pop_front();
            if (upcase && b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
            m_data  = b;
            m_start = 1'b1;
            m_since = 0;
        end
        if (rx_ready) begin
            m_last = rx_data;
            if (mq.size() < DEPTH) mq.push_back(rx_data);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr_overflow) m_ovf = 1'b0;
    endtask

    task automatic idle_inputs();
        rx_ready     = 1'b0;
        rx_data      = 8'h00;
        tx_busy      = 1'b0;
        upcase       = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic push(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
    endtask

    // Returns the number of ticks until tx_start is seen, or -1 if the bound expires.
    task automatic wait_pulse(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start && n < max);
        if (!tx_start) n = -1;
    endtask

    initial begin
        int n;
        int pulses;

        tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 8'h41};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 3'd0, 1'b0, 8'h41};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 3'd0, 1'b0, 8'h41};
        tbl[3]  = '{1'b1, 8'h61, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41, 3'd1, 1'b0, 8'h61};
        tbl[4]  = '{1'b1, 8'h7A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 3'd1, 1'b0, 8'h7A};
        tbl[5]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41, 3'd2, 1'b0, 8'h41};
        tbl[6]  = '{1'b1, 8'h7B, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41, 3'd3, 1'b0, 8'h7B};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 3'd2, 1'b0, 8'h7B};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 3'd2, 1'b0, 8'h7B};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 3'd2, 1'b0, 8'h7B};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 3'd1, 1'b0, 8'h7B};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41, 3'd1, 1'b0, 8'h7B};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41, 3'd1, 1'b0, 8'h7B};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7B, 3'd0, 1'b0, 8'h7B};
        tbl[14] = '{1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7B, 3'd1, 1'b0, 8'h61};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7B, 3'd1, 1'b0, 8'h61};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h61, 3'd0, 1'b0, 8'h61};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h61, 3'd0, 1'b0, 8'h61};

        // Reset values
        do_reset();
        chk("rst_tx_start",  32'(tx_start),  32'd0);
        chk("rst_tx_data",   32'(tx_data),   32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_last_byte", 32'(last_byte), 32'd0);

        // Single byte latency and upper-case mode
        for (int i = 0; i < 18; i++) begin
            rx_ready     = tbl[i].rx;
            rx_data      = tbl[i].d;
            tx_busy      = tbl[i].busy;
            upcase       = tbl[i].up;
            clr_overflow = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_tx_start", i), 32'(tx_start),  32'(tbl[i].st));
            chk($sformatf("vec%0d_tx_data", i),  32'(tx_data),   32'(tbl[i].td));
            chk($sformatf("vec%0d_count", i),    32'(count),     32'(tbl[i].cnt));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow),  32'(tbl[i].ovf));
            chk($sformatf("vec%0d_last", i),     32'(last_byte), 32'(tbl[i].last));
        end

        // Burst, overflow, and push+pop at full
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        chk("burst_count", 32'(count), 32'd4);
        chk("burst_no_start", 32'(tx_start), 32'd0);
        push(8'h55);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_last", 32'(last_byte), 32'h55);
        clr_overflow = 1'b1;
        push(8'h56);
        chk("ovf_clr_vs_drop", 32'(overflow), 32'd1);
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        tx_busy  = 1'b0;
        push(8'h14);
        chk("full_pp_start", 32'(tx_start), 32'd1);
        chk("full_pp_data", 32'(tx_data), 32'h10);
        chk("full_pp_count", 32'(count), 32'd4);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 5; i++) begin
            wait_pulse(6, n);
            chk($sformatf("order%0d_gap", i), 32'(n), 32'd3);
            chk($sformatf("order%0d_data", i), 32'(tx_data), 32'(8'h10 + 8'(i)));
        end
        tick();
        chk("burst_drained", 32'(count), 32'd0);

        // Second burst wraps both pointers; each pulse waits on tx_busy
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        pulses = 0;
        repeat (5) begin
            tick();
            if (tx_start) pulses++;
        end
        chk("busy_blocks", 32'(pulses), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tx_busy = 1'b0;
            wait_pulse(4, n);
            chk($sformatf("wrap%0d_wait", i), 32'(n), 32'd1);
            chk($sformatf("wrap%0d_data", i), 32'(tx_data), 32'(8'h20 + 8'(i)));
            tx_busy = 1'b1;
            pulses = 0;
            repeat (4) begin
                tick();
                if (tx_start) pulses++;
            end
            chk($sformatf("wrap%0d_hold", i), 32'(pulses), 32'd0);
        end
        tx_busy = 1'b0;
        tick();
        chk("wrap_drained", 32'(count), 32'd0);

        // Reset in the cycle tx_start is high
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        push(8'hEE);
        tx_busy = 1'b0;
        tick();
        chk("rstmid_pre_start", 32'(tx_start), 32'd1);
        chk("rstmid_pre_ovf", 32'(overflow), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_start", 32'(tx_start), 32'd0);
        chk("rstmid_count", 32'(count), 32'd0);
        chk("rstmid_ovf", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            tick();
            if (tx_start) pulses++;
        end
        chk("rstmid_silent", 32'(pulses), 32'd0);
        push(8'hB5);
        chk("rstmid_new_count", 32'(count), 32'd1);
        chk("rstmid_new_nostart", 32'(tx_start), 32'd0);
        tick();
        chk("rstmid_new_start", 32'(tx_start), 32'd1);
        chk("rstmid_new_data", 32'(tx_data), 32'hB5);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rx_ready     = ($urandom_range(0, 9) < 4);
            rx_data      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h5E, 8'h7D));
            tx_busy      = ($urandom_range(0, 9) < 5);
            upcase       = 1'($urandom);
            clr_overflow = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd_tx_start", 32'(tx_start),  32'(m_start));
            chk("rnd_tx_data",  32'(tx_data),   32'(m_data));
            chk("rnd_count",    32'(count),     32'(mq.size()));
            chk("rnd_overflow", 32'(overflow),  32'(m_ovf));
            chk("rnd_last",     32'(last_byte), 32'(m_last));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_mirror_fifo.md
# uart_mirror_fifo

Buffered UART byte mirror with a parametrised receive FIFO between `uart_rx` and `uart_tx`. Bytes arriving faster than they can be retransmitted are queued rather than lost, and are sent back in arrival order. An optional upper-case mode rewrites bytes on the way out. Overflow status, fill level and the last received byte are exported for the hex display and debug pins.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `WIDTH`, 8: data width in bits; upper-case mode is active only when `WIDTH == 8`.

Ports:
- `clk` in 1: single clock; every register is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_ready` in 1: one-cycle pulse from `uart_rx`; `rx_data` is valid in that cycle.
- `rx_data` in WIDTH: received byte.
- `tx_busy` in 1: `uart_tx` is shifting a byte out.
- `upcase` in 1: when 1, bytes 0x61..0x7A are sent as the value minus 0x20.
- `clr_overflow` in 1: clears the `overflow` flag.
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `tx_data` out WIDTH: byte presented to `uart_tx`.
- `count` out $clog2(DEPTH)+1: current FIFO fill level, 0..DEPTH.
- `overflow` out 1: sticky flag, set when a received byte was dropped.
- `last_byte` out WIDTH: raw value of the most recent `rx_ready` byte.

## Operation
- **FIFO storage.** Circular buffer with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits and wrapping modulo DEPTH. `count` is tracked explicitly. The storage array is not reset.
- **Push.** On `rx_ready`, the byte is written and `count` increments, provided `count < DEPTH` or a pop happens in the same cycle.
  - If the FIFO is full and there is no pop, the byte is dropped, `overflow` is set, and `wp` and `count` stay unchanged.
- **Pop.** Performed by the TX FSM, which removes the entry at `rp`.
  - Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- **`last_byte`.** Loaded on every `rx_ready`, including bytes that are dropped.
- **`overflow`.**
  - Set on a drop; cleared by `clr_overflow`.
  - If a drop and `clr_overflow` occur in the same cycle, set wins.
- **TX FSM** (states IDLE, START, GUARD):
  - IDLE: if `count != 0` and `!tx_busy`, register `tx_data` = the (possibly upper-cased) entry at `rp`, pop it, set `tx_start` = 1, and go to START.
  - START: `tx_start` = 0; go to GUARD.
  - GUARD: one dead cycle that lets `uart_tx` raise `tx_busy`; go to IDLE.
- **`tx_data`.** Holds its value until the next IDLE→START transition.
- **Upper-casing.** Applied at pop time using the value of `upcase` in the pop cycle. Stored data is never modified.

## Timing
- **Reset values:** `tx_start` = 0, `tx_data` = 0, `count` = 0, `overflow` = 0, `last_byte` = 0, FSM in IDLE, `wp` = `rp` = 0. Reset takes effect immediately (asynchronous).
- **Reset mid-operation:** queued bytes are discarded. A `tx_start` pulse in flight is cut short. No byte is emitted after reset until a new `rx_ready` arrives.
- **Latency:** with `rx_ready` in cycle N, an empty FIFO, FSM in IDLE and `tx_busy` = 0:
  - `count` = 1 in N+1;
  - `tx_start` is high exactly in cycle N+2, with `tx_data` valid in that cycle;
  - `count` returns to 0 in N+2.
- **Handshake:**
  - `tx_start` is never high for two consecutive cycles.
  - Minimum spacing between `tx_start` pulses is 3 cycles.
  - `uart_tx` must assert `tx_busy` no later than 2 cycles after `tx_start`.
  - A new start is issued only from IDLE with `tx_busy` = 0.
- **Output timing:** `count`, `overflow` and `last_byte` are registered and update the cycle after the causing event.
- **Pointer wrap-around:** `wp`/`rp` roll from DEPTH−1 to 0 with no bubble.

## Test plan
- **Single byte.** Stimulus: `rx_ready` with 0x41, `tx_busy` tied low. Required: `tx_start` high only in cycle N+2, `tx_data` = 0x41, `last_byte` = 0x41, `count` sequence 0→1→0.
- **Burst and ordering (DEPTH = 4).** Stimulus: hold `tx_busy` = 1, push 0x10..0x13, then release `tx_busy`. Required: `count` = 4; bytes are emitted in the order 0x10, 0x11, 0x12, 0x13 at ≥ 3-cycle spacing, each pulse waiting on `tx_busy`; pointers wrap correctly on a second burst.
- **Overflow.** Stimulus: full FIFO with `tx_busy` = 1, push 0x55. Required: byte dropped, `overflow` = 1, `count` = 4, `last_byte` = 0x55.
  - Then `clr_overflow` together with another drop: `overflow` stays 1.
  - Then `clr_overflow` alone: `overflow` = 0.
- **Push and pop at full.** Stimulus: FIFO full, FSM in IDLE, `tx_busy` falls in the same cycle as `rx_ready`. Required: byte accepted, `count` stays 4, `overflow` stays 0.
- **Upper-case mode.** Stimulus: `upcase` = 1; push 0x61, 0x7A, 0x41, 0x7B. Required: `tx_data` = 0x41, 0x5A, 0x41, 0x7B. With `upcase` = 0, the bytes are sent unchanged.
- **Reset mid-transmission.** Stimulus: assert `rst` in the cycle `tx_start` = 1 with 3 bytes queued. Required: `tx_start` drops immediately, `count` = 0, `overflow` = 0, and no `tx_start` pulse follows until a new `rx_ready`.
